// File: rtl/fifo_burst_pkg.sv
// Shared types and helpers for the FIFO burst drainer.
//   state_e     : drainer FSM state (idle / bursting)
//   burst_beats : beats to move in one burst = min(fill, effective burst length)
package fifo_burst_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } state_e;

  // A programmed length of 0 means a full FIFO's worth (2^lgflen beats).
  function automatic int unsigned burst_beats(int unsigned fill, int unsigned burst_len,
                                              int unsigned lgflen);
    int unsigned eff_len;
    eff_len = (burst_len == 0) ? (32'd1 << lgflen) : burst_len;
    return (fill < eff_len) ? fill : eff_len;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-deep registered AXI-stream output stage.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   load_i              : capture data_i/last_i and raise valid
//   data_i, last_i      : beat to capture
//   ready_i             : downstream ready; drops valid when accepted with no new load
//   valid_o/data_o/last_o : registered stream outputs
module axis_out_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic             last_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;
  logic             last_q, last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (valid_q && ready_i) begin
      // Data and last hold after acceptance; only a new load changes them.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/fifo_burst_drain.sv
// Drains a first-word-fall-through FIFO onto an AXI-stream master in bounded bursts.
// A burst starts on the FIFO threshold flag, or after data has waited i_timeout cycles.
//   i_clk, i_reset_n          : clock, asynchronous active-low reset
//   o_rd                      : FIFO read strobe (combinational)
//   i_data, i_empty, i_fill   : FIFO read data, empty flag, occupancy
//   i_int                     : FIFO threshold flag
//   i_burst_len               : max beats per burst (0 = 2^LGFLEN)
//   i_timeout                 : idle cycles before partial flush (0 = disabled)
//   M_AXIS_*                  : registered stream master
//   o_busy                    : high while bursting
module fifo_burst_drain
  import fifo_burst_pkg::*;
#(
  parameter int unsigned BW        = 8,
  parameter int unsigned LGFLEN    = 4,
  parameter int unsigned LGTIMEOUT = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  output logic                 o_rd,
  input  logic [BW-1:0]        i_data,
  input  logic                 i_empty,
  input  logic [LGFLEN:0]      i_fill,
  input  logic                 i_int,
  input  logic [LGFLEN:0]      i_burst_len,
  input  logic [LGTIMEOUT-1:0] i_timeout,
  output logic                 M_AXIS_TVALID,
  input  logic                 M_AXIS_TREADY,
  output logic [BW-1:0]        M_AXIS_TDATA,
  output logic                 M_AXIS_TLAST,
  output logic                 o_busy
);

  localparam int unsigned FW = LGFLEN + 1;

  state_e               state_q, state_d;
  logic [LGTIMEOUT-1:0] idle_cnt_q, idle_cnt_d;
  logic [LGFLEN:0]      remaining_q, remaining_d;

  logic timed_out;
  logic start;
  logic rd;
  logic out_valid;

  assign timed_out = (i_timeout != '0) && (idle_cnt_q >= i_timeout);
  assign start     = (state_q == StIdle) && !i_empty && (i_int || timed_out);

  // Only this block reads the FIFO, so remaining never exceeds fill; the empty
  // term is a safety net, not a wait condition.
  assign rd = (state_q == StBurst) && (remaining_q != '0) && !i_empty
              && (!out_valid || M_AXIS_TREADY);

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    remaining_d = remaining_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          remaining_d = FW'(burst_beats(int'(unsigned'(i_fill)), int'(unsigned'(i_burst_len)),
                                        LGFLEN));
          idle_cnt_d  = '0;
          state_d     = StBurst;
        end else if (i_empty) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q != '1) begin
          idle_cnt_d = idle_cnt_q + LGTIMEOUT'(1);
        end
      end
      StBurst: begin
        if (rd) begin
          remaining_d = remaining_q - FW'(1);
        end
        // Leave on the edge that loads the final beat; it may still be pending downstream.
        if (remaining_d == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      idle_cnt_q  <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      remaining_q <= remaining_d;
    end
  end

  axis_out_reg #(
    .Width(BW)
  ) u_out (
    .clk_i  (i_clk),
    .rst_ni (i_reset_n),
    .load_i (rd),
    .data_i (i_data),
    .last_i (remaining_q == FW'(1)),
    .ready_i(M_AXIS_TREADY),
    .valid_o(out_valid),
    .data_o (M_AXIS_TDATA),
    .last_o (M_AXIS_TLAST)
  );

  assign o_rd          = rd;
  assign M_AXIS_TVALID = out_valid;
  assign o_busy        = (state_q == StBurst);

endmodule

// File: doc/fifo_burst_drain.md
# fifo_burst_drain

Read-side companion to the synchronous threshold FIFO: watches the FIFO fill level and threshold flag, then drains the FIFO onto an AXI-stream master as bounded bursts with TLAST on the final beat. A burst starts when the threshold flag is set, or when data has sat in a non-empty FIFO for a programmable idle timeout. Sits directly downstream of the FIFO, driving its read strobe and consuming its first-word-fall-through read data.

## Interface
- BW, 8: data width; matches the FIFO.
- LGFLEN, 4: log2 FIFO depth; fill and length ports are LGFLEN+1 bits.
- LGTIMEOUT, 8: width of the idle timeout counter.

- i_clk  in  1  clock; all logic on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- o_rd  out  1  FIFO read strobe (combinational).
- i_data  in  BW  FIFO read data, valid whenever i_empty is low (async read).
- i_empty  in  1  FIFO empty.
- i_fill  in  LGFLEN+1  FIFO occupancy.
- i_int  in  1  FIFO threshold flag (fill >= threshold).
- i_burst_len  in  LGFLEN+1  maximum beats per burst; 0 means 2^LGFLEN.
- i_timeout  in  LGTIMEOUT  idle cycles before a partial flush; 0 disables timeout.
- M_AXIS_TVALID  out  1  stream valid (registered).
- M_AXIS_TREADY  in  1  stream ready.
- M_AXIS_TDATA  out  BW  stream data (registered).
- M_AXIS_TLAST  out  1  last beat of burst (registered).
- o_busy  out  1  high while in BURST state.

## Operation
- States: IDLE, BURST. Reset: IDLE, M_AXIS_TVALID=0, TDATA=0, TLAST=0, o_busy=0, idle counter=0, remaining=0.
- IDLE: idle counter increments each cycle with !i_empty (saturates at all-ones), clears when i_empty. Start condition: !i_empty && (i_int || (i_timeout!=0 && idle_cnt >= i_timeout)).
- On start: remaining <= min(i_fill, eff_len), eff_len = (i_burst_len==0) ? 2^LGFLEN : i_burst_len; idle counter cleared; go BURST. i_burst_len/i_timeout changes during a burst have no effect until next start.
- Because only this block reads the FIFO, remaining <= fill throughout; BURST never waits on empty.
- o_rd = (state==BURST) && remaining!=0 && !i_empty && (!M_AXIS_TVALID || M_AXIS_TREADY).
- On o_rd: output register loads TDATA<=i_data, TVALID<=1, TLAST<=(remaining==1); remaining decrements.
- On TVALID && TREADY with no o_rd: TVALID<=0 (TDATA, TLAST hold; TLAST cleared only on next load).
- BURST -> IDLE when remaining reaches 0 (same edge as the final load); the final beat may still be pending on the stream. IDLE counting and a new start may proceed while it is pending; the new burst's first o_rd waits on the output register.
- AXI rules: TVALID, once high, stays high with TDATA/TLAST stable until TREADY.
- Asynchronous reset mid-burst: all state cleared immediately; the partial burst is abandoned without TLAST.

## Timing
- i_int rising seen at edge N -> o_busy and o_rd possible in cycle N+1 -> TVALID at N+2.
- Timeout: with i_timeout=T and FIFO non-empty from cycle 0, start at edge T+1 (counter reaches T after T edges, decision registered).
- Throughput: one beat per cycle with TREADY held high; zero bubbles inside a burst; one cycle between bursts (IDLE decision).
- o_rd is combinational in TREADY, i_empty; no combinational path from TREADY to TVALID.

## Structure
- Package (fifo_burst_pkg): state enum {IDLE, BURST}; function for eff_len/min clamp.
- One natural sub-module: axis_out_reg (one-deep registered output stage with load/accept).

## Test plan
- Threshold start: burst_len=4, FIFO fills to 6, i_int pulses, TREADY=1 -> four beats on consecutive cycles, TLAST on 4th, o_rd exactly 4 cycles, 2 words remain.
- Timeout flush: timeout=10, write 3 words, i_int low -> burst of 3 starts 11 cycles after first write, TLAST on 3rd beat.
- Backpressure: burst_len=8, TREADY toggles 1/0 -> TDATA/TLAST stable while TVALID&&!TREADY, 8 beats in order, no duplicates or drops.
- burst_len=0 with 16 words -> single 16-beat burst, TLAST on beat 16.
- Timeout=0, 1 word, i_int low for 1000 cycles -> no o_rd, TVALID stays 0.
- Reset_n low mid-burst (after beat 2 of 5) -> TVALID, TLAST, o_busy 0 immediately; after release, IDLE with counter 0.
